// File: rtl/program_counter.sv
// Instruction-fetch sequencer for the PucCPU: selects the next PC from opcode, immediate and register.
// Optional return stack for CALL/RET is compiled in with `define PC_CALL_STACK_EN.
module program_counter #(
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned OPCODE_WIDTH   = 6,
  parameter int unsigned VALUE_WIDTH    = 8,
  parameter int unsigned REGISTER_WIDTH = 8
`ifdef PC_CALL_STACK_EN
  ,
  parameter int unsigned STACK_DEPTH    = 4
`endif
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [OPCODE_WIDTH-1:0]   resetCode,
  input  logic [VALUE_WIDTH-1:0]    instructionValue,
  input  logic [REGISTER_WIDTH-1:0] registerValue,
  output logic [PC_WIDTH-1:0]       pc
);

  localparam logic [OPCODE_WIDTH-1:0] OP_RST  = OPCODE_WIDTH'(6'h3F);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(6'h22);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_JNZ  = OPCODE_WIDTH'(6'h24);
  localparam logic [OPCODE_WIDTH-1:0] OP_JN   = OPCODE_WIDTH'(6'h25);
  localparam logic [OPCODE_WIDTH-1:0] OP_JR   = OPCODE_WIDTH'(6'h26);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6'h27);
`ifdef PC_CALL_STACK_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(6'h28);
  localparam logic [OPCODE_WIDTH-1:0] OP_RET  = OPCODE_WIDTH'(6'h29);
`endif

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] imm_target;
  logic [PC_WIDTH-1:0] reg_target;
  logic                reg_is_zero;
  logic                reg_is_neg;

  // Operands enter the PC unsigned: truncated or zero-extended, never sign-extended.
  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign imm_target  = PC_WIDTH'(instructionValue);
  assign reg_target  = PC_WIDTH'(registerValue);
  assign reg_is_zero = (registerValue == '0);
  assign reg_is_neg  = registerValue[REGISTER_WIDTH-1];

`ifdef PC_CALL_STACK_EN
  localparam int unsigned SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q, sp_d, sp_next, sp_prev;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stack_wr_en;

  // Circular pointer: a push on a full stack overwrites the oldest entry.
  assign sp_next = (sp_q == SP_W'(STACK_DEPTH - 1)) ? '0 : sp_q + SP_W'(1);
  assign sp_prev = (sp_q == '0) ? SP_W'(STACK_DEPTH - 1) : sp_q - SP_W'(1);
`endif

  // Next-PC selection; anything not decoded below simply advances.
  always_comb begin
    pc_d = pc_inc;
`ifdef PC_CALL_STACK_EN
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    stack_wr_en = 1'b0;
`endif
    case (resetCode)
      OP_RST:  pc_d = '0;
      OP_JMP:  pc_d = imm_target;
      OP_JZ:   pc_d = reg_is_zero ? imm_target : pc_inc;
      OP_JNZ:  pc_d = reg_is_zero ? pc_inc : imm_target;
      OP_JN:   pc_d = reg_is_neg ? imm_target : pc_inc;
      OP_JR:   pc_d = reg_target;
      OP_HALT: pc_d = pc_q;
`ifdef PC_CALL_STACK_EN
      OP_CALL: begin
        pc_d        = imm_target;
        stack_wr_en = 1'b1;
        sp_d        = sp_next;
        if (cnt_q != CNT_W'(STACK_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
      end
      OP_RET: begin
        if (cnt_q != '0) begin
          pc_d  = stack_q[sp_prev];
          sp_d  = sp_prev;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clock) begin
    if (stack_wr_en && !isReset) begin
      stack_q[sp_q] <= pc_inc;
    end
  end
`endif

  assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter; expected PCs queued at drive time, compared after the edge.
module tb_program_counter;

  localparam logic [5:0] OP_ALU  = 6'h01;
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_RST  = 6'h3F;
  localparam logic [5:0] OP_JMP  = 6'h22;
  localparam logic [5:0] OP_JZ   = 6'h23;
  localparam logic [5:0] OP_JNZ  = 6'h24;
  localparam logic [5:0] OP_JN   = 6'h25;
  localparam logic [5:0] OP_JR   = 6'h26;
  localparam logic [5:0] OP_HALT = 6'h27;
  localparam logic [5:0] OP_CALL = 6'h28;
  localparam logic [5:0] OP_RET  = 6'h29;

  logic       clock;
  logic       isReset;
  logic [5:0] resetCode;
  logic [7:0] instructionValue;
  logic [7:0] registerValue;
  logic [7:0] pc;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  program_counter dut (
    .clock            (clock),
    .isReset          (isReset),
    .resetCode        (resetCode),
    .instructionValue (instructionValue),
    .registerValue    (registerValue),
    .pc               (pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive, queue expectation, compare just after the rising edge.
  task automatic step(input string tag, input logic [5:0] op, input logic [7:0] imm,
                      input logic [7:0] rv, input logic [7:0] exp);
    logic [7:0] e;
    resetCode        = op;
    instructionValue = imm;
    registerValue    = rv;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, pc, ~exp);
    end else begin
      e = exp_q.pop_front();
      check(tag, pc, e);
    end
    @(negedge clock);
  endtask

  task automatic go(input logic [7:0] target);
    step("goto", OP_JMP, target, 8'h00, target);
  endtask

  initial begin
    isReset          = 1'b1;
    resetCode        = OP_RST;
    instructionValue = 8'h00;
    registerValue    = 8'h00;
    repeat (2) @(posedge clock);
    #1 check("por", pc, 8'h00);
    @(negedge clock);
    isReset = 1'b0;

    for (int i = 1; i <= 5; i++) step("inc", OP_ALU, 8'h00, 8'h00, 8'(i));

    // Asynchronous reset mid-cycle, then precedence over a pending jump.
    #2 isReset = 1'b1;
    #1 check("async_rst", pc, 8'h00);
    @(negedge clock);
    for (int i = 0; i < 3; i++) step("rst_hold", OP_JMP, 8'h44, 8'h00, 8'h00);
    isReset = 1'b0;
    step("post_rst", OP_ALU, 8'h00, 8'h00, 8'h01);

    step("jmp", OP_JMP, 8'h40, 8'h00, 8'h40);
    step("jr", OP_JR, 8'h00, 8'h10, 8'h10);
    step("jr_noext", OP_JR, 8'h00, 8'h80, 8'h80);

    go(8'h20); step("jz_t",  OP_JZ,  8'h05, 8'h00, 8'h05);
    go(8'h20); step("jz_n",  OP_JZ,  8'h05, 8'h03, 8'h21);
    go(8'h20); step("jnz_t", OP_JNZ, 8'h05, 8'h03, 8'h05);
    go(8'h20); step("jnz_n", OP_JNZ, 8'h05, 8'h00, 8'h21);
    go(8'h20); step("jn_t",  OP_JN,  8'h05, 8'hFF, 8'h05);
    go(8'h20); step("jn_n",  OP_JN,  8'h05, 8'h7F, 8'h21);

    go(8'hFF); step("wrap", OP_NOP, 8'h00, 8'h00, 8'h00);
    go(8'h12);
    for (int i = 0; i < 3; i++) step("halt", OP_HALT, 8'h77, 8'h00, 8'h12);
    go(8'h30); step("sw_rst", OP_RST, 8'h55, 8'h00, 8'h00);

`ifdef PC_CALL_STACK_EN
    step("ret_empty0", OP_RET, 8'h00, 8'h00, 8'h01);
    go(8'h10);
    step("call", OP_CALL, 8'h50, 8'h00, 8'h50);
    step("ret", OP_RET, 8'h00, 8'h00, 8'h11);
    go(8'h60);
    for (int i = 1; i <= 5; i++) step("ncall", OP_CALL, 8'(i), 8'h00, 8'(i));
    step("nret1", OP_RET, 8'h00, 8'h00, 8'h05);
    step("nret2", OP_RET, 8'h00, 8'h00, 8'h04);
    step("nret3", OP_RET, 8'h00, 8'h00, 8'h03);
    step("nret4", OP_RET, 8'h00, 8'h00, 8'h02);
    step("nret5_empty", OP_RET, 8'h00, 8'h00, 8'h03);
`else
    go(8'h10);
    step("call_inc", OP_CALL, 8'h50, 8'h00, 8'h11);
    step("ret_inc", OP_RET, 8'h00, 8'h00, 8'h12);
`endif

    if (exp_q.size() != 0) check("sb_leftover", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
